// File: rtl/pc_fetch_unit.sv
// Purpose : program counter plus single-outstanding instruction fetch stage feeding decode.
// Latency : imem_req rises the cycle after retire; the instruction is valid the cycle after imem_ack.
// Backpres: decode stalls via instr_ready=0 (instr held, no new fetch); memory stalls via withheld imem_ack.
//
// Ports:
//   clock, resetn          - rising-edge clock, asynchronous active-low reset
//   next_pc, is_branch     - redirect target and select from the branch/link unit (sampled at retire)
//   halt                   - decoded halt (sampled at retire)
//   pc, pc_inc             - current PC and pc+1 (combinational) for the branch/link unit
//   imem_req/addr/ack/data - level-held fetch request to instruction memory
//   instr, instr_valid,
//   instr_ready            - instruction handed to decode with a valid/ready handshake
//   halted, fault          - terminal states: halt retired, or ack timeout (both sticky until reset)
module pc_fetch_unit #(
  parameter int                ADDR_W      = 8,
  parameter int                INSTR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                ACK_TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [ADDR_W-1:0]  next_pc,
  input  logic               is_branch,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_inc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               halted,
  output logic               fault
);

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_HOLD   = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  // The counter holds the number of unacknowledged request cycles already
  // spent; the cycle in which it equals ACK_TIMEOUT-1 is the last allowed
  // one, so imem_req is high for exactly ACK_TIMEOUT cycles before a fault.
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] ack_cnt;
  logic       capture;
  logic       retire;
  logic       time_out;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and per-cycle control strobes
  // ---------------------------------------------------------------------------
  // imem_req is decoded from state so that an asynchronous reset (which forces
  // BOOT) drops the request immediately, abandoning any outstanding fetch.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    time_out  = 1'b0;
    case (state)
      ST_BOOT: begin
        // One quiet cycle after reset release; a stray ack here is ignored.
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          // An ack in the final allowed cycle still wins over the timeout.
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end else if (ack_cnt >= TIMEOUT_LAST) begin
          time_out  = 1'b1;
          state_nxt = ST_FAULT;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          retire    = 1'b1;
          state_nxt = halt ? ST_HALTED : ST_FETCH;
        end
      end
      ST_HALTED: begin
        state_nxt = ST_HALTED;
      end
      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end
      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: PC, instruction register, timeout counter, sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      ack_cnt     <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      // Counter runs only while a request stays unacknowledged; any exit from
      // FETCH (ack or timeout) or any other state clears it.
      if (state == ST_FETCH && state_nxt == ST_FETCH) begin
        ack_cnt <= ack_cnt + 8'd1;
      end else begin
        ack_cnt <= '0;
      end

      if (capture) begin
        instr       <= imem_data;
        instr_valid <= 1'b1;
      end else if (retire) begin
        instr_valid <= 1'b0;
      end

      // Branch inputs and halt only matter in the retire cycle.
      if (retire) begin
        pc <= is_branch ? next_pc : pc_inc;
        if (halt) begin
          halted <= 1'b1;
        end
      end

      if (time_out) begin
        fault <= 1'b1;
      end
    end
  end

  // Sequential next address wraps modulo 2^ADDR_W with no overflow indication.
  assign pc_inc    = pc + ADDR_W'(1);
  assign imem_addr = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clock;
  logic        resetn;
  logic [7:0]  next_pc;
  logic        is_branch;
  logic        halt;
  logic [7:0]  pc;
  logic [7:0]  pc_inc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;
  logic        fault;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit dut (
    .clock       (clock),
    .resetn      (resetn),
    .next_pc     (next_pc),
    .is_branch   (is_branch),
    .halt        (halt),
    .pc          (pc),
    .pc_inc      (pc_inc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted),
    .fault       (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One record = inputs held for one clock, then outputs expected after that edge.
  typedef struct {
    logic        ack;
    logic [15:0] dat;
    logic        rdy;
    logic        br;
    logic [7:0]  npc;
    logic        hlt;
    logic        req_e;
    logic [7:0]  pc_e;
    logic [15:0] instr_e;
    logic        vld_e;
  } vec_t;

  vec_t vecs[27];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic ack, input logic [15:0] dat, input logic rdy,
                     input logic br, input logic [7:0] npc, input logic hlt);
    imem_ack    = ack;
    imem_data   = dat;
    instr_ready = rdy;
    is_branch   = br;
    next_pc     = npc;
    halt        = hlt;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack    = 1'b0;
    imem_data   = 16'h0;
    instr_ready = 1'b0;
    is_branch   = 1'b0;
    next_pc     = 8'h00;
    halt        = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset just released (FSM in BOOT).
  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    idle_inputs();
    #1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_vld", instr_valid, 1'b0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fault", fault, 1'b0);
    @(posedge clock);
    #1;
    chk("rst_hold_req", imem_req, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //              ack dat       rdy br npc    hlt req pc     instr     vld
    vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 16'h1000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h1000, 1'b1};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 16'h1000, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 16'h1000, 1'b0};
    vecs[5]  = '{1'b1, 16'h1001, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 16'h1001, 1'b1};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 16'h1001, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 16'h1001, 1'b0};
    vecs[8]  = '{1'b1, 16'h1002, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 16'h1002, 1'b1};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 16'h1002, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 16'h1002, 1'b0};
    vecs[11] = '{1'b1, 16'h1003, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 16'h1003, 1'b1};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 16'h1003, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 16'h1003, 1'b0};
    vecs[14] = '{1'b1, 16'h1004, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 16'h1004, 1'b1};
    vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 16'h1004, 1'b0};
    vecs[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 16'h1004, 1'b0};
    vecs[17] = '{1'b1, 16'h1005, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 16'h1005, 1'b1};
    vecs[18] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h40, 1'b0, 1'b1, 8'h40, 16'h1005, 1'b0};
    vecs[19] = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 16'h1005, 1'b0};
    vecs[20] = '{1'b1, 16'h1040, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 16'h1040, 1'b1};
    vecs[21] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h99, 1'b0, 1'b1, 8'h41, 16'h1040, 1'b0};
    // instr_ready without a valid instruction, then ack ignored while holding
    vecs[22] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 16'h1040, 1'b0};
    vecs[23] = '{1'b1, 16'h1041, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 16'h1041, 1'b1};
    vecs[24] = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 16'h1041, 1'b1};
    vecs[25] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h42, 16'h1041, 1'b0};
    // same-cycle ack
    vecs[26] = '{1'b1, 16'h1042, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h42, 16'h1042, 1'b1};

    resetn = 1'b0;
    idle_inputs();

    // ---- table: sequential fetch, branch, ignored ack/ready ----
    do_reset();
    for (int i = 0; i < 27; i++) begin
      logic [7:0] inc_e;
      cyc(vecs[i].ack, vecs[i].dat, vecs[i].rdy, vecs[i].br, vecs[i].npc, vecs[i].hlt);
      inc_e = vecs[i].pc_e + 8'h01;
      chk($sformatf("v%0d_req", i), imem_req, vecs[i].req_e);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].pc_e);
      chk($sformatf("v%0d_pc_inc", i), pc_inc, inc_e);
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].pc_e);
      chk($sformatf("v%0d_instr", i), instr, vecs[i].instr_e);
      chk($sformatf("v%0d_vld", i), instr_valid, vecs[i].vld_e);
      chk($sformatf("v%0d_flags", i), {halted, fault}, 2'b00);
    end

    // ---- decode stall at pc=FF and wrap to 00 ----
    do_reset();
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);   // BOOT
    cyc(1'b1, 16'h2000, 1'b0, 1'b0, 8'h00, 1'b0);   // ack -> HOLD
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 8'hFF, 1'b0);   // retire, branch to FF
    chk("wrap_pc_ff", pc, 8'hFF);
    chk("wrap_pc_inc_ff", pc_inc, 8'h00);
    cyc(1'b1, 16'h20FF, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 16'h0000, 1'b0, 1'b1, 8'h33, 1'b1);  // stalled: branch/halt ignored
      chk($sformatf("stall%0d_vld", i), instr_valid, 1'b1);
      chk($sformatf("stall%0d_instr", i), instr, 16'h20FF);
      chk($sformatf("stall%0d_req", i), imem_req, 1'b0);
      chk($sformatf("stall%0d_pc", i), pc, 8'hFF);
    end
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 8'h33, 1'b0);
    chk("wrap_pc", pc, 8'h00);
    chk("wrap_addr", imem_addr, 8'h00);
    chk("wrap_req", imem_req, 1'b1);
    chk("wrap_pc_inc", pc_inc, 8'h01);

    // ---- halt at pc=07 ----
    do_reset();
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 16'h1100, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 8'h07, 1'b0);
    cyc(1'b1, 16'h1107, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("halt_pre_pc", pc, 8'h07);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 8'h77, 1'b1);
    chk("halt_halted", halted, 1'b1);
    chk("halt_pc", pc, 8'h08);
    chk("halt_req", imem_req, 1'b0);
    chk("halt_vld", instr_valid, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc((i % 2) == 0, 16'hAAAA, (i % 2) == 1, 1'b1, 8'h55, 1'b1);
      chk($sformatf("halted%0d_state", i), {halted, fault, imem_req, instr_valid}, 4'b1000);
      chk($sformatf("halted%0d_pc", i), pc, 8'h08);
      chk($sformatf("halted%0d_instr", i), instr, 16'h1107);
    end

    // ---- timeout: never ack ----
    do_reset();
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);   // BOOT -> first req cycle
    for (int i = 1; i < 15; i++) begin
      cyc(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
      chk($sformatf("to_wait%0d", i), {imem_req, fault}, 2'b10);
    end
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);   // 15th req cycle, no ack
    chk("to_fault", fault, 1'b1);
    chk("to_req", imem_req, 1'b0);
    chk("to_halted", halted, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc((i % 2) == 0, 16'h5555, 1'b1, 1'b0, 8'h00, 1'b0);
      chk($sformatf("to_sticky%0d", i), {fault, imem_req, instr_valid, halted}, 4'b1000);
    end

    // ---- timeout: ack in the 15th request cycle wins ----
    do_reset();
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i < 15; i++) begin
      cyc(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
    end
    chk("late_req_still", imem_req, 1'b1);
    cyc(1'b1, 16'h3333, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("late_fault", fault, 1'b0);
    chk("late_vld", instr_valid, 1'b1);
    chk("late_instr", instr, 16'h3333);
    chk("late_req", imem_req, 1'b0);

    // ---- asynchronous reset mid-fetch at pc=22, ack during BOOT ----
    do_reset();
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 16'h4400, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 8'h22, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("ar_pre_req", imem_req, 1'b1);
    chk("ar_pre_pc", pc, 8'h22);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_req", imem_req, 1'b0);
    chk("ar_pc", pc, 8'h00);
    chk("ar_vld", instr_valid, 1'b0);
    chk("ar_instr", instr, 16'h0000);
    @(negedge clock);
    imem_ack  = 1'b1;
    imem_data = 16'hDEAD;
    resetn    = 1'b1;
    @(posedge clock);
    #1;
    chk("boot_ack_vld", instr_valid, 1'b0);
    chk("boot_ack_instr", instr, 16'h0000);
    chk("boot_ack_req", imem_req, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("boot_ack_after", {imem_req, instr_valid, fault}, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
